// File: rtl/controller_pkg.sv
// Shared controller types: bus scheduler state encoding and requester port indices.
package controller_pkg;

  typedef enum logic [1:0] {WAIT, GRANT, BUSY} bus_sched_state_e;

  localparam int BUS_REQ_CTRL = 0;
  localparam int BUS_REQ_HJ   = 1;

endpackage

// File: rtl/bus_cond_detector.sv
// START/STOP detector on synchronized SCL/SDA: one sample register plus one history register per line.
module bus_cond_detector (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic start_o,
  output logic stop_o
);

  logic scl_q, sda_q, scl_p_q, sda_p_q;
  logic scl_hi;

  // Idle bus reads high; resetting to 1 avoids a phantom edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_q   <= scl_i;
      sda_q   <= sda_i;
      scl_p_q <= scl_q;
      sda_p_q <= sda_q;
    end
  end

  assign scl_hi  = scl_q & scl_p_q;
  assign start_o = scl_hi &  sda_p_q & ~sda_q;
  assign stop_o  = scl_hi & ~sda_p_q &  sda_q;

endmodule

// File: rtl/bus_access_sched.sv
// Bus access scheduler: START/STOP tracking, timer sequencing and two-port grant FSM.
// Optional: BUS_SCHED_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module bus_access_sched
  import controller_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic       bus_free_i,
  input  logic       bus_available_i,
  input  logic       bus_idle_i,
  output logic       timer_restart_o,
  output logic       timer_enable_o,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       start_det_o,
  output logic       stop_det_o
);

  bus_sched_state_e state_q, state_d;
  logic       quiet_q, quiet_d;
  logic [1:0] gnt_q, gnt_d;
  logic       owner_q, owner_d;
  logic       start_det_q, stop_det_q, restart_q, enable_q;
  logic       start, stop, rel_to_wait, pick;
  logic [1:0] elig;

  bus_cond_detector u_det (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .start_o(start),
    .stop_o (stop)
  );

  // bus_free_i is carried for the parent's timer wiring; only available/idle gate grants.
  assign elig[BUS_REQ_CTRL] = req_i[BUS_REQ_CTRL] & bus_available_i & (bus_free_i | 1'b1);
  assign elig[BUS_REQ_HJ]   = req_i[BUS_REQ_HJ]   & bus_idle_i;

`ifdef BUS_SCHED_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign pick = (&elig) ? ~last_q : elig[BUS_REQ_HJ];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  assign pick = ~elig[BUS_REQ_CTRL];
`endif

  always_comb begin
    state_d     = state_q;
    quiet_d     = quiet_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rel_to_wait = 1'b0;
`ifdef BUS_SCHED_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      WAIT: begin
        if (start) begin
          state_d = BUSY;
        end else if (|elig) begin
          state_d     = GRANT;
          gnt_d       = 2'b00;
          gnt_d[pick] = 1'b1;
          owner_d     = pick;
          quiet_d     = 1'b1;
`ifdef BUS_SCHED_ROUND_ROBIN_EN
          last_d      = pick;
`endif
        end
      end
      GRANT: begin
        if (start)     quiet_d = 1'b0;
        else if (stop) quiet_d = 1'b1;
        // Owner release: a START without its STOP leaves the bus to foreign traffic.
        if (!req_i[owner_q]) begin
          gnt_d       = 2'b00;
          state_d     = quiet_d ? WAIT : BUSY;
          rel_to_wait = quiet_d;
        end
      end
      BUSY: begin
        if (stop) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WAIT;
      quiet_q     <= 1'b1;
      gnt_q       <= 2'b00;
      owner_q     <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      restart_q   <= 1'b1;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      quiet_q     <= quiet_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      start_det_q <= start;
      stop_det_q  <= stop;
      restart_q   <= start | stop | rel_to_wait;
      enable_q    <= (state_d == WAIT);
    end
  end

  assign gnt_o           = gnt_q;
  assign start_det_o     = start_det_q;
  assign stop_det_o      = stop_det_q;
  assign timer_restart_o = restart_q;
  assign timer_enable_o  = enable_q;

endmodule
